// File: rtl/tone_pkg.sv
// Shared constants and types for the DDS tone datapath sequencer.
// Address classes and master-count phase markers are common to all tone blocks.
package tone_pkg;

    localparam int MCOUNT_W = 10;

    localparam logic [1:0] ADDR_INCR = 2'd0;
    localparam logic [1:0] ADDR_VOL  = 2'd1;
    localparam logic [1:0] ADDR_WAVE = 2'd2;

    // Datapath phases within a sample frame; the mix result is final at MIX_DONE.
    localparam int PH_ACC   = 0;
    localparam int PH_LUT   = 4;
    localparam int PH_MIX   = 8;
    localparam int MIX_DONE = 11;

    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_entry_t;

endpackage

// File: rtl/tone_write_scheduler_fifo.sv
// Synchronous FIFO with flush, full/empty flags and occupancy level.
// Depth must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage has no reset; validity is tracked by the pointers and level alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/tone_write_scheduler.sv
// Master sample counter plus a write buffer that releases host register writes
// only after the mix completes, so each frame sees one consistent configuration.
module tone_write_scheduler
    import tone_pkg::*;
#(
    parameter int PERIOD     = 1024,
    parameter int FIFO_DEPTH = 4,
    parameter int SAFE_START = 12
) (
    input  logic                          clk_in,
    input  logic                          reset_in,
    input  logic                          flush_in,
    input  logic                          wr_valid_in,
    output logic                          wr_ready_out,
    input  logic [3:0]                    wr_addr_in,
    input  logic [15:0]                   wr_data_in,
    output logic [MCOUNT_W-1:0]           master_count_out,
    output logic                          frame_start_out,
    output logic [15:0]                   data_out,
    output logic [3:0]                    addr_out,
    output logic                          data_valid_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out
);

    localparam logic [MCOUNT_W-1:0] LAST_COUNT = MCOUNT_W'(PERIOD - 1);
    localparam logic [MCOUNT_W-1:0] WIN_LO     = MCOUNT_W'(SAFE_START - 1);
    localparam logic [MCOUNT_W-1:0] WIN_HI     = MCOUNT_W'(PERIOD - 2);

    logic [MCOUNT_W-1:0] count;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic                in_window;
    wr_entry_t           in_entry;
    wr_entry_t           head;

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            count <= '0;
        end else if (count == LAST_COUNT) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign master_count_out = count;
    assign frame_start_out  = (count == '0);

    // Ready follows the registered level only, so a same-cycle pop never frees a slot early.
    assign wr_ready_out = !full && !reset_in;
    assign push         = wr_valid_in && wr_ready_out;
    assign in_entry     = '{addr: wr_addr_in, data: wr_data_in};

    // Decide one cycle early so the strobe lands in [SAFE_START, PERIOD-1].
    assign in_window = (count >= WIN_LO) && (count <= WIN_HI);
    assign pop       = !empty && in_window && !flush_in;

    sync_fifo #(
        .WIDTH ($bits(wr_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_in),
        .rst     (reset_in),
        .flush   (flush_in),
        .push    (push),
        .pop     (pop),
        .wr_data (in_entry),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level_out)
    );

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            data_valid_out <= 1'b0;
            data_out       <= '0;
            addr_out       <= '0;
        end else begin
            data_valid_out <= pop;
            if (pop) begin
                data_out <= head.data;
                addr_out <= head.addr;
            end
        end
    end

endmodule
